// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit: shift-add multiply, restoring divide,
// HI/LO register pair with mthi/mtlo writes while idle.
module mult_div_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO
);

  localparam int unsigned CW = $clog2(ITER);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DZ} state_e;

  state_e              state_q, state_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN-1:0]     dvsr_q, dvsr_d;
  logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                is_div_q, is_div_d;
  logic                neg_q, neg_d;
  logic                neg_rem_q, neg_rem_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;

  logic                a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic [XLEN-1:0]     quot, rem;
  logic [2*XLEN-1:0]   prod_neg;

  always_comb begin
    a_neg     = ~op[0] & A[XLEN-1];
    b_neg     = ~op[0] & B[XLEN-1];
    a_mag     = a_neg ? -A : A;
    b_mag     = b_neg ? -B : B;
    // prod_q holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, dvsr_q} : '0);
    div_shift = prod_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, dvsr_q};
    quot      = prod_q[XLEN-1:0];
    rem       = prod_q[2*XLEN-1:XLEN];
    prod_neg  = -prod_q;
  end

  always_comb begin
    state_d   = state_q;
    prod_d    = prod_q;
    dvsr_d    = dvsr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d     = '0;
          is_div_d  = op[1];
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (op[1]) begin
            if (B == '0) begin
              state_d = S_DZ;
              prod_d  = {{XLEN{1'b0}}, A};
            end else begin
              state_d = S_DIV;
              dvsr_d  = b_mag;
              prod_d  = {{XLEN{1'b0}}, a_mag};
            end
          end else begin
            state_d = S_MUL;
            dvsr_d  = a_mag;
            prod_d  = {{XLEN{1'b0}}, b_mag};
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_MUL: begin
        prod_d = {mul_sum, prod_q[XLEN-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
      end
      S_DIV: begin
        if (!div_diff[XLEN]) prod_d = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        else                 prod_d = {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = neg_q ? -quot : quot;
          hi_d = neg_rem_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = neg_q ? prod_neg : prod_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_DZ: begin
        hi_d    = prod_q[XLEN-1:0];
        lo_d    = '1;
        done_d  = 1'b1;
        dbz_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      prod_q    <= '0;
      dvsr_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prod_q    <= prod_d;
      dvsr_q    <= dvsr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency/handshake, signed/unsigned results,
// divide by zero, ignored start/mthi while busy, mthi/mtlo and reset abort.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] A, B, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] HI, LO;

  int tests = 0;
  int fails = 0;

  mult_div_unit #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start at E0, expect completion at edge E<lat>; operands scrambled after E0.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic we_lo, input int lat,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz);
    logic [31:0] hi0, lo0;
    int viol;
    hi0 = HI; lo0 = LO;
    op = o; A = a; B = b; start = 1'b1; lo_we = we_lo; wdata = 32'h0000AAAA;
    tick();
    start = 1'b0; lo_we = 1'b0;
    A = $urandom; B = $urandom;
    chk({tag, " busy@E0"}, {31'd0, busy}, 32'd1);
    chk({tag, " HI hold"}, HI, hi0);
    chk({tag, " LO hold"}, LO, lo0);
    viol = 0;
    for (int i = 1; i < lat; i++) begin
      tick();
      if (busy !== 1'b1 || done !== 1'b0) viol++;
    end
    chk({tag, " busy window"}, viol, 32'd0);
    tick();
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " busy end"}, {31'd0, busy}, 32'd0);
    chk({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, edz});
    chk({tag, " HI"}, HI, eh);
    chk({tag, " LO"}, LO, el);
    tick();
    chk({tag, " done 1cyc"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; A = '0; B = '0; wdata = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst dbz", {31'd0, div_by_zero}, 32'd0);
    chk("rst HI", HI, 32'd0);
    chk("rst LO", LO, 32'd0);

    run_op("MULT -2*3",  2'b00, 32'hFFFFFFFE, 32'h3, 1'b0, 33, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    run_op("MULTU",      2'b01, 32'hFFFFFFFE, 32'h3, 1'b0, 33, 32'h00000002, 32'hFFFFFFFA, 1'b0);
    run_op("DIV -7/2",   2'b10, 32'hFFFFFFF9, 32'h2, 1'b0, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("DIVU 7/0",   2'b11, 32'h7,        32'h0, 1'b0, 1,  32'h00000007, 32'hFFFFFFFF, 1'b1);
    run_op("DIV ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 33, 32'h0, 32'h80000000, 1'b0);
    run_op("DIVU 100/7", 2'b11, 32'd100,      32'd7, 1'b0, 33, 32'd2, 32'd14, 1'b0);
    run_op("DIV 7/-2",   2'b10, 32'd7,        32'hFFFFFFFE, 1'b0, 33, 32'd1, 32'hFFFFFFFD, 1'b0);

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h12345678;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi", HI, 32'h12345678);
    chk("mtlo", LO, 32'h12345678);
    run_op("MULTU+lo_we", 2'b01, 32'd3, 32'd4, 1'b1, 33, 32'd0, 32'd12, 1'b0);

    // start/mthi while busy must be ignored
    op = 2'b01; A = 32'h10000; B = 32'h10000; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    op = 2'b11; A = 32'd9; B = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; hi_we = 1'b1; wdata = 32'hDEADBEEF;
    tick();
    hi_we = 1'b0;
    chk("busy mthi drop", HI, 32'd0);
    for (int i = 7; i <= 32; i++) tick();
    chk("ign pre done", {31'd0, done}, 32'd0);
    tick();
    chk("ign done", {31'd0, done}, 32'd1);
    chk("ign HI", HI, 32'd1);
    chk("ign LO", LO, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    chk("no 2nd op", ndone, 32'd0);

    // reset aborts an operation mid-flight
    op = 2'b00; A = 32'd123; B = 32'hFFFFFF00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort HI", HI, 32'd0);
    chk("abort LO", LO, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("abort no done", ndone, 32'd0);
    run_op("MULT 5*6", 2'b00, 32'd5, 32'd6, 1'b0, 33, 32'd0, 32'd30, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit in the execute stage, beside the ALU.
- Takes the same A/B operands the ALU takes and writes the HI/LO register pair.
- HI/LO feed back into the execute result mux for mfhi/mflo.
- Control stalls the pipeline while busy is high.

Parameters:
- XLEN, 32, operand and HI/LO width; only 32 is supported.
- ITER, 32, number of iteration cycles per mul/div. Must equal XLEN.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request operation; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  input  32  multiplicand / dividend (rs)
- B  input  32  multiplier / divisor (rt)
- hi_we  input  1  mthi write enable
- lo_we  input  1  mtlo write enable
- wdata  input  32  mthi/mtlo data
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle pulse; HI/LO updated
- div_by_zero  output  1  one-cycle pulse with done on division by zero
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset, synchronous: state=IDLE, HI=LO=0, busy=0, done=0, div_by_zero=0, all internal registers 0. A reset during an operation aborts it and leaves no partial result.
- States:
  - IDLE: waiting for start.
  - MUL: 32 shift-add iterations, one bit per cycle.
  - DIV: 32 restoring-division iterations, one bit per cycle.
  - FIX: sign correction and HI/LO write.
- Start: if start=1 in IDLE at edge E0:
  - Latch op and A/B magnitudes. For signed ops, a negative operand becomes its two's-complement magnitude.
  - Latch result sign flags.
  - Go to MUL or DIV, or go to the div-by-zero path.
- Iterations: the ITER state runs at edges E1..E32. FIX runs at edge E33: HI/LO are written and state returns to IDLE.
- Handshake:
  - done=1 and busy=0 in the cycle after E33.
  - busy=1 in the cycles between E0 and E33.
  - done lasts exactly one cycle.
  - A new start may be sampled in the cycle where done=1.
- Multiply:
  - The 64-bit product goes to {HI,LO}.
  - MULT negates the 64-bit product if sign(A) xor sign(B).
  - MULTU is unsigned throughout.
- Divide:
  - LO=quotient, HI=remainder.
  - DIV truncates toward zero: quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No trap.
- Divide by zero (B==0, op DIV/DIVU):
  - No iterations. At E1: LO=0xFFFFFFFF, HI=A as latched, unsigned.
  - done=1 and div_by_zero=1 for one cycle after E1.
- start while busy: ignored. It is not queued and the operation in flight is undisturbed.
- mthi/mtlo:
  - In IDLE, hi_we/lo_we write wdata to HI/LO at the edge. Both may be written in the same cycle.
  - While busy, writes are dropped.
  - start and hi_we/lo_we in the same IDLE cycle: start wins and the writes are dropped.
- Outputs:
  - HI/LO are stable except at FIX, the div-by-zero edge, mthi/mtlo, or reset.
  - Operands changing after E0 have no effect.

Test Plan:
- MULT A=0xFFFFFFFE, B=0x00000003, start at E0 -> busy for E0..E33; at E33 HI=0xFFFFFFFF, LO=0xFFFFFFFA; done pulse one cycle.
- MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA at E33; then DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7, B=0 -> at E1 LO=0xFFFFFFFF, HI=0x00000007; done=div_by_zero=1 for one cycle; busy one cycle only. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULTU 0x10000*0x10000 started; start with DIVU 9/3 pulsed at E5, and hi_we with wdata=0xDEADBEEF at E6 -> both ignored; at E33 HI=1, LO=0; no second done.
- Idle cycle: hi_we=lo_we=1, wdata=0x12345678 -> HI=LO=0x12345678. Next cycle: start=1 with lo_we=1 -> write dropped and operation starts.
- MULT started, reset=1 at E10 -> next cycle busy=0, HI=LO=0, no done. New MULT 5*6 afterwards -> LO=30, HI=0 after 33 edges.
